// File: rtl/alu_issue_unit.sv
// Issues one op at a time to a combinational ALU and returns the result with its tag; macro ALU_ISSUE_PERF_EN adds response/stall counters.
// Latency accept->rsp_valid: 2 cycles single-cycle ops, MULTI_CYCLES+1 for MUL/DIV/MOD, 1 for the divide-by-zero trap.
// Backpressure: req_ready low in EXEC, follows rsp_ready in RESP; response is held stable while rsp_ready is low.

`ifndef ALU_ADD
`define ALU_ADD 4'd0
`define ALU_SUB 4'd1
`define ALU_MUL 4'd2
`define ALU_DIV 4'd3
`define ALU_MOD 4'd4
`define ALU_AND 4'd5
`define ALU_OR  4'd6
`define ALU_XOR 4'd7
`define ALU_SLL 4'd8
`define ALU_SRL 4'd9
`define ALU_EQ  4'd10
`define ALU_NE  4'd11
`define ALU_LT  4'd12
`define ALU_LE  4'd13
`define ALU_GE  4'd14
`endif

module alu_issue_unit #(
    parameter int WORD_SIZE    = 64,
    parameter int TAG_WIDTH    = 4,
    parameter int MULTI_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WORD_SIZE-1:0] req_a,
    input  logic [WORD_SIZE-1:0] req_b,
    input  logic [3:0]           req_op,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    output logic [3:0]           alu_op,
    input  logic [WORD_SIZE-1:0] alu_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_result,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    output logic                 rsp_err
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]          perf_ops,
    output logic [31:0]          perf_stall
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [7:0] MULTI_LOAD = 8'(MULTI_CYCLES - 1);

    state_t               state;
    logic [7:0]           cnt;
    logic [TAG_WIDTH-1:0] tag;
    logic                 accept;
    logic                 is_multi;
    logic                 div_zero;

    // Accepting in RESP requires the current response to leave on the same edge.
    assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign accept    = req_valid && req_ready;
    assign is_multi  = (req_op == `ALU_MUL) || (req_op == `ALU_DIV) || (req_op == `ALU_MOD);
    assign div_zero  = ((req_op == `ALU_DIV) || (req_op == `ALU_MOD)) && (req_b == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            tag        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 4'd0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                EXEC: begin
                    if (cnt == 8'd0) begin
                        rsp_result <= alu_out;
                        rsp_err    <= 1'b0;
                        rsp_tag    <= tag;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Later assignments override the RESP->IDLE step for a back-to-back accept.
            if (accept) begin
                alu_a  <= req_a;
                alu_b  <= req_b;
                alu_op <= req_op;
                tag    <= req_tag;
                if (div_zero) begin
                    state      <= RESP;
                    cnt        <= 8'd0;
                    rsp_valid  <= 1'b1;
                    rsp_err    <= 1'b1;
                    rsp_tag    <= req_tag;
                    rsp_result <= (req_op == `ALU_DIV) ? {WORD_SIZE{1'b1}} : req_a;
                end else begin
                    state <= EXEC;
                    cnt   <= is_multi ? MULTI_LOAD : 8'd0;
                end
            end
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_ops   <= 32'd0;
            perf_stall <= 32'd0;
        end else begin
            if (rsp_valid && rsp_ready)
                perf_ops <= perf_ops + 32'd1;
            if (rsp_valid && !rsp_ready)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
